// File: rtl/freq_meter.sv
// freq_meter: measures a slow asynchronous signal against clk.
// The input is synchronised and reduced to a one-cycle rise pulse. Rise pulses
// are counted over a fixed gate window, either once per start pulse or
// back-to-back while cont is held. The interval between consecutive rises is
// measured independently, and no_signal flags an input that has stopped.
module freq_meter #(
   parameter int GATE_CYCLES    = 125000000,
   parameter int TIMEOUT_CYCLES = 250000000,
   parameter int CNT_W          = 32,
   parameter int SYNC_STAGES    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   input  logic             cont,
   output logic             busy,
   output logic             result_valid,
   output logic [CNT_W-1:0] edge_count,
   output logic             overflow,
   output logic [CNT_W-1:0] last_period,
   output logic             period_valid,
   output logic             no_signal
);

   localparam int               GATE_W     = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LOAD  = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_V  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_GATE = 1'b1
   } state_t;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic             inc);
      if (inc && (v != CNT_MAX))
         return v + CNT_W'(1);
      return v;
   endfunction

   // True when an increment is requested but the value is already saturated.
   function automatic logic sat_hit(input logic [CNT_W-1:0] v,
                                    input logic             inc);
      return inc && (v == CNT_MAX);
   endfunction

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_rise;

   state_t                 r_state;
   logic [GATE_W-1:0]      r_gate_cnt;
   logic [CNT_W-1:0]       r_acc;
   logic                   r_acc_ovf;
   logic [CNT_W-1:0]       w_acc_next;
   logic                   w_ovf_next;

   logic [CNT_W-1:0]       r_per_cnt;
   logic                   r_armed;

   // Bring sig_in into the clk domain and keep one extra delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
   // Accumulator value including this cycle's rise; also used for the terminal cycle.
   assign w_acc_next = sat_add(r_acc, w_rise);
   assign w_ovf_next = r_acc_ovf | sat_hit(r_acc, w_rise);

   // Gate window FSM: counts rises for exactly GATE_CYCLES cycles and publishes the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_gate_cnt   <= '0;
         r_acc        <= '0;
         r_acc_ovf    <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         edge_count   <= '0;
         overflow     <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_GATE;
                  r_gate_cnt <= GATE_LOAD;
                  r_acc      <= '0;
                  r_acc_ovf  <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            S_GATE: begin
               if (r_gate_cnt == '0) begin
                  // Terminal cycle: its own rise still belongs to this window.
                  edge_count   <= w_acc_next;
                  overflow     <= w_ovf_next;
                  result_valid <= 1'b1;
                  r_acc        <= '0;
                  r_acc_ovf    <= 1'b0;
                  if (cont) begin
                     // Next cycle is already cycle 0 of the following window.
                     r_gate_cnt <= GATE_LOAD;
                  end else begin
                     r_state <= S_IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  r_gate_cnt <= r_gate_cnt - GATE_W'(1);
                  r_acc      <= w_acc_next;
                  r_acc_ovf  <= w_ovf_next;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Period measurement and loss-of-signal detection, independent of the gate window.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_per_cnt    <= '0;
         r_armed      <= 1'b0;
         last_period  <= '0;
         period_valid <= 1'b0;
         no_signal    <= 1'b0;
      end else if (w_rise) begin
         // The rise cycle itself counts as 1 toward the next interval.
         r_per_cnt <= CNT_W'(1);
         r_armed   <= 1'b1;
         no_signal <= 1'b0;
         if (r_armed) begin
            last_period  <= r_per_cnt;
            period_valid <= 1'b1;
         end
      end else if (r_per_cnt == TIMEOUT_V) begin
         // Counter is parked at the timeout; last_period is left stale on purpose.
         no_signal    <= 1'b1;
         period_valid <= 1'b0;
         r_armed      <= 1'b0;
      end else begin
         r_per_cnt <= r_per_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed scenarios for freq_meter with hand-computed expectations.
// Inputs are driven 1 ns after a rising edge and sampled by the DUT at the next
// edge; outputs are read at the same point. A rise "at window cycle c" needs
// sig_in high on the input driven at loop step c-1 (two synchroniser flops plus
// the prev flop), and its effect is visible after loop step c+1.
module tb_freq_meter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: GATE=100, TIMEOUT=50, CNT_W=8
   logic       rst, sig_in, start, cont;
   logic       busy, result_valid, overflow, period_valid, no_signal;
   logic [7:0] edge_count, last_period;

   // Saturation instance: GATE=100, TIMEOUT=20, CNT_W=5
   logic       sig2, start2, cont2;
   logic       busy2, rv2, ovf2, pv2, ns2;
   logic [4:0] ec2, lp2;

   int n_cmp = 0;
   int n_err = 0;

   logic       pat [0:511];
   int         rv_cnt;
   int         rv_k  [8];
   logic [7:0] rv_ec [8];
   logic       rv_ov [8];

   freq_meter #(.GATE_CYCLES(100), .TIMEOUT_CYCLES(50), .CNT_W(8), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
      .busy(busy), .result_valid(result_valid), .edge_count(edge_count),
      .overflow(overflow), .last_period(last_period), .period_valid(period_valid),
      .no_signal(no_signal)
   );

   freq_meter #(.GATE_CYCLES(100), .TIMEOUT_CYCLES(20), .CNT_W(5), .SYNC_STAGES(2)) u_ovf (
      .clk(clk), .rst(rst), .sig_in(sig2), .start(start2), .cont(cont2),
      .busy(busy2), .result_valid(rv2), .edge_count(ec2),
      .overflow(ovf2), .last_period(lp2), .period_valid(pv2),
      .no_signal(ns2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pat();
      for (int i = 0; i < 512; i++) pat[i] = 1'b0;
      rv_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         rv_k[i]  = -1;
         rv_ec[i] = '0;
         rv_ov[i] = 1'b0;
      end
   endtask

   // Two-cycle-high pulse producing one rise at window cycle c (c >= 1).
   task automatic add_rise(input int c);
      pat[c-1] = 1'b1;
      pat[c]   = 1'b1;
   endtask

   task automatic rec(input int k);
      if (result_valid === 1'b1) begin
         if (rv_cnt < 8) begin
            rv_k[rv_cnt]  = k;
            rv_ec[rv_cnt] = edge_count;
            rv_ov[rv_cnt] = overflow;
         end
         rv_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sig_in = 1'b0; start = 1'b0; cont = 1'b0;
      sig2 = 1'b0; start2 = 1'b0; cont2 = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({busy, result_valid, overflow, period_valid, no_signal} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b required 00000",
                  {busy, result_valid, overflow, period_valid, no_signal});
      end
      n_cmp++;
      if (edge_count !== 8'd0) begin
         n_err++; $display("FAIL reset_edge_count: got %0d required 0", edge_count);
      end
      n_cmp++;
      if (last_period !== 8'd0) begin
         n_err++; $display("FAIL reset_last_period: got %0d required 0", last_period);
      end
      n_cmp++;
      if ({busy2, rv2, ovf2, pv2, ns2, ec2, lp2} !== 15'd0) begin
         n_err++; $display("FAIL reset_ovf_inst: got %h required 0", {busy2, rv2, ovf2, pv2, ns2, ec2, lp2});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_window();
      clear_pat();
      for (int j = 0; j < 10; j++) add_rise(3 + 10 * j);
      cont = 1'b0;
      for (int k = 0; k <= 120; k++) begin
         start  = (k == 0);
         sig_in = pat[k];
         tick();
         rec(k);
         if (k == 50) begin
            n_cmp++;
            if (busy !== 1'b1) begin
               n_err++; $display("FAIL single_busy_mid: got %b required 1", busy);
            end
         end
      end
      start = 1'b0; sig_in = 1'b0;
      n_cmp++;
      if (rv_cnt !== 1) begin
         n_err++; $display("FAIL single_pulse_count: got %0d required 1", rv_cnt);
      end
      n_cmp++;
      if (rv_k[0] !== 100) begin
         n_err++; $display("FAIL single_pulse_time: got %0d required 100", rv_k[0]);
      end
      n_cmp++;
      if (rv_ec[0] !== 8'd10 || rv_ov[0] !== 1'b0) begin
         n_err++; $display("FAIL single_count: got %0d/%b required 10/0", rv_ec[0], rv_ov[0]);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL single_busy_after: got %b required 0", busy);
      end
      n_cmp++;
      if (last_period !== 8'd10 || period_valid !== 1'b1) begin
         n_err++; $display("FAIL single_period: got %0d/%b required 10/1", last_period, period_valid);
      end
   endtask

   // Rises on the last cycle of window 1 and the first cycle of window 3.
   task automatic test_boundary();
      int exp_ec [3] = '{1, 1, 2};
      clear_pat();
      add_rise(99); add_rise(150); add_rise(200); add_rise(299);
      for (int k = 0; k <= 320; k++) begin
         start  = (k == 0);
         cont   = (k < 250);
         sig_in = pat[k];
         tick();
         rec(k);
         if (k == 100 || k == 200) begin
            n_cmp++;
            if (busy !== 1'b1) begin
               n_err++; $display("FAIL boundary_no_gap k=%0d: busy %b required 1", k, busy);
            end
         end
      end
      start = 1'b0; cont = 1'b0; sig_in = 1'b0;
      n_cmp++;
      if (rv_cnt !== 3) begin
         n_err++; $display("FAIL boundary_pulse_count: got %0d required 3", rv_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rv_k[i] !== 100 * (i + 1)) begin
            n_err++; $display("FAIL boundary_time[%0d]: got %0d required %0d", i, rv_k[i], 100 * (i + 1));
         end
         n_cmp++;
         if (rv_ec[i] !== 8'(exp_ec[i])) begin
            n_err++; $display("FAIL boundary_count[%0d]: got %0d required %0d", i, rv_ec[i], exp_ec[i]);
         end
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL boundary_idle: busy %b required 0", busy);
      end
   endtask

   // Three chained windows, cont dropped in the fourth, stray start at step 150.
   task automatic test_continuous();
      int exp_ec [4] = '{1, 1, 1, 2};
      clear_pat();
      add_rise(5); add_rise(105); add_rise(205); add_rise(305); add_rise(355);
      for (int k = 0; k <= 430; k++) begin
         start  = (k == 0) || (k == 150);
         cont   = (k < 350);
         sig_in = pat[k];
         tick();
         rec(k);
      end
      start = 1'b0; cont = 1'b0; sig_in = 1'b0;
      n_cmp++;
      if (rv_cnt !== 4) begin
         n_err++; $display("FAIL cont_pulse_count: got %0d required 4", rv_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (rv_k[i] !== 100 * (i + 1)) begin
            n_err++; $display("FAIL cont_time[%0d]: got %0d required %0d", i, rv_k[i], 100 * (i + 1));
         end
         n_cmp++;
         if (rv_ec[i] !== 8'(exp_ec[i])) begin
            n_err++; $display("FAIL cont_count[%0d]: got %0d required %0d", i, rv_ec[i], exp_ec[i]);
         end
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL cont_idle: busy %b required 0", busy);
      end
   endtask

   // Rises at cycles 5,15 then silence, then 80,87.
   task automatic test_timeout();
      clear_pat();
      add_rise(5); add_rise(15); add_rise(80); add_rise(87);
      for (int k = 0; k <= 100; k++) begin
         sig_in = pat[k];
         tick();
         if (k == 16) begin
            n_cmp++;
            if (last_period !== 8'd10 || period_valid !== 1'b1) begin
               n_err++; $display("FAIL to_period10: got %0d/%b required 10/1", last_period, period_valid);
            end
         end
         if (k == 65) begin
            n_cmp++;
            if (no_signal !== 1'b0 || period_valid !== 1'b1) begin
               n_err++; $display("FAIL to_before: ns/pv got %b/%b required 0/1", no_signal, period_valid);
            end
         end
         if (k == 66) begin
            n_cmp++;
            if (no_signal !== 1'b1 || period_valid !== 1'b0 || last_period !== 8'd10) begin
               n_err++; $display("FAIL to_expired: ns/pv/lp got %b/%b/%0d required 1/0/10",
                                 no_signal, period_valid, last_period);
            end
         end
         if (k == 81) begin
            n_cmp++;
            if (no_signal !== 1'b0 || period_valid !== 1'b0) begin
               n_err++; $display("FAIL to_rearm: ns/pv got %b/%b required 0/0", no_signal, period_valid);
            end
         end
         if (k == 88) begin
            n_cmp++;
            if (last_period !== 8'd7 || period_valid !== 1'b1) begin
               n_err++; $display("FAIL to_period7: got %0d/%b required 7/1", last_period, period_valid);
            end
         end
      end
      sig_in = 1'b0;
   endtask

   // Reset at window cycle 40, restart one cycle later.
   task automatic test_reset_mid();
      clear_pat();
      add_rise(10); add_rise(20); add_rise(30); add_rise(60); add_rise(70);
      for (int k = 0; k <= 160; k++) begin
         start  = (k == 0) || (k == 42);
         rst    = (k == 41);
         sig_in = pat[k];
         tick();
         rec(k);
         if (k == 40) begin
            n_cmp++;
            if (busy !== 1'b1 || last_period !== 8'd10 || edge_count !== 8'd2) begin
               n_err++; $display("FAIL rstmid_pre: busy/lp/ec got %b/%0d/%0d required 1/10/2",
                                 busy, last_period, edge_count);
            end
         end
         if (k == 41) begin
            n_cmp++;
            if ({busy, result_valid, overflow, period_valid, no_signal} !== 5'b0 ||
                edge_count !== 8'd0 || last_period !== 8'd0) begin
               n_err++; $display("FAIL rstmid_clear: flags %b ec %0d lp %0d required 0",
                                 {busy, result_valid, overflow, period_valid, no_signal},
                                 edge_count, last_period);
            end
         end
      end
      start = 1'b0; rst = 1'b0; sig_in = 1'b0;
      n_cmp++;
      if (rv_cnt !== 1 || rv_k[0] !== 142) begin
         n_err++; $display("FAIL rstmid_pulse: count %0d at %0d required 1 at 142", rv_cnt, rv_k[0]);
      end
      n_cmp++;
      if (rv_ec[0] !== 8'd2) begin
         n_err++; $display("FAIL rstmid_count: got %0d required 2", rv_ec[0]);
      end
   endtask

   // 5-bit counter: 33 rises saturate at 31 with overflow; exactly 31 rises do not.
   task automatic test_overflow();
      int n_rise [2] = '{33, 31};
      logic [4:0] got_ec;
      logic       got_ov;
      int         got_cnt;
      for (int w = 0; w < 2; w++) begin
         clear_pat();
         for (int j = 0; j < n_rise[w]; j++) add_rise(1 + 3 * j);
         got_cnt = 0; got_ec = '0; got_ov = 1'b0;
         for (int k = 0; k <= 110; k++) begin
            start2 = (k == 0);
            sig2   = pat[k];
            tick();
            if (rv2 === 1'b1) begin
               got_cnt++; got_ec = ec2; got_ov = ovf2;
               n_cmp++;
               if (k !== 100) begin
                  n_err++; $display("FAIL ovf_time[%0d]: got %0d required 100", w, k);
               end
            end
         end
         start2 = 1'b0; sig2 = 1'b0;
         n_cmp++;
         if (got_cnt !== 1 || got_ec !== 5'd31 || got_ov !== (w == 0)) begin
            n_err++; $display("FAIL ovf_result[%0d]: pulses %0d ec %0d ovf %b required 1/31/%b",
                              w, got_cnt, got_ec, got_ov, (w == 0));
         end
      end
      n_cmp++;
      if (lp2 !== 5'd3) begin
         n_err++; $display("FAIL ovf_period: got %0d required 3", lp2);
      end
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_boundary();
      test_continuous();
      test_timeout();
      test_reset_mid();
      test_overflow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
